// File: rtl/sdram_pkg.sv
// Shared widths, FSM state encoding and the test-pattern generator for the
// SDRAM test master.
package sdram_pkg;

   localparam int ADDR_W = 23;
   localparam int DATA_W = 32;
   localparam int MASK_W = 4;

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] WAIT_READY = 3'd1;
   localparam logic [2:0] WR_REQ     = 3'd2;
   localparam logic [2:0] WR_WAIT    = 3'd3;
   localparam logic [2:0] RD_REQ     = 3'd4;
   localparam logic [2:0] RD_WAIT    = 3'd5;
   localparam logic [2:0] CHECK      = 3'd6;
   localparam logic [2:0] DONE       = 3'd7;

   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] seed);
      return {9'b0, a} ^ seed;
   endfunction

endpackage

// File: rtl/sdram_test_master_if.sv
// SoC-side handshake bundle between the test master and an SDRAM controller.
interface sdram_test_master_if;
   import sdram_pkg::*;

   logic              ready;
   logic              busy;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wr_data;
   logic [MASK_W-1:0] wr_mask;
   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;

   modport master (input ready, busy, rd_data,
                   output addr, wr_data, wr_mask, wr_en, rd_en);
   modport slave  (output ready, busy, rd_data,
                   input addr, wr_data, wr_mask, wr_en, rd_en);

endinterface

// File: rtl/sdram_timeout_counter.sv
// Handshake watchdog: down-counter reloaded on clear, expires at terminal count
// while enabled.
module sdram_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= CW'(TIMEOUT_CYCLES);
      end else if (enable && count != '0) begin
         count <= count - CW'(1);
      end
   end

   assign expired = enable && !clear && (count == '0);

endmodule

// File: rtl/sdram_test_master.sv
// Writes a seeded address pattern through the SoC-side SDRAM port, reads it back
// and reports mismatches, with a watchdog on every controller handshake.
module sdram_test_master
   import sdram_pkg::*;
#(
   parameter logic [ADDR_W-1:0] START_ADDR     = 23'd0,
   parameter int unsigned       WORD_COUNT     = 1024,
   parameter logic [DATA_W-1:0] SEED           = 32'hCCF0_F0F1,
   parameter int unsigned       TIMEOUT_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              reset_port,
   input  logic              start_port,
   input  logic              soc_side_ready_port,
   input  logic              soc_side_busy_port,
   output logic [ADDR_W-1:0] soc_side_addr_port,
   output logic [DATA_W-1:0] soc_side_wr_data_port,
   output logic [MASK_W-1:0] soc_side_wr_mask_port,
   output logic              soc_side_wr_en_port,
   output logic              soc_side_rd_en_port,
   input  logic [DATA_W-1:0] soc_side_rd_data_port,
   output logic              done_port,
   output logic              pass_port,
   output logic              timeout_port,
   output logic [15:0]       error_count_port,
   output logic [ADDR_W-1:0] first_error_addr_port
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORD_COUNT - 1);

   logic [2:0]        state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] word_idx;
   logic [DATA_W-1:0] wr_data;
   logic [MASK_W-1:0] wr_mask;
   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] rd_capture;
   logic              done;
   logic              pass;
   logic              timeout;
   logic [15:0]       error_count;
   logic [ADDR_W-1:0] first_error_addr;
   logic              tmr_clear;
   logic              waiting;
   logic              expired;
   logic              mismatch;

   assign waiting  = (state == WAIT_READY) || (state == WR_REQ) || (state == WR_WAIT) ||
                     (state == RD_REQ) || (state == RD_WAIT);
   assign mismatch = (rd_capture != pattern(addr, SEED));

   // Timer restarts on every state change, so each handshake edge gets its own budget.
   sdram_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk     (clk),
      .reset   (reset_port),
      .clear   (tmr_clear),
      .enable  (waiting),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (reset_port) begin
         state            <= IDLE;
         addr             <= '0;
         word_idx         <= '0;
         wr_data          <= '0;
         wr_mask          <= '0;
         wr_en            <= 1'b0;
         rd_en            <= 1'b0;
         rd_capture       <= '0;
         done             <= 1'b0;
         pass             <= 1'b0;
         timeout          <= 1'b0;
         error_count      <= '0;
         first_error_addr <= '0;
         tmr_clear        <= 1'b1;
      end else begin
         tmr_clear <= 1'b0;
         if (expired) begin
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            timeout <= 1'b1;
            pass    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
         end else begin
            case (state)
               IDLE, DONE: if (start_port) begin
                  done             <= 1'b0;
                  pass             <= 1'b0;
                  timeout          <= 1'b0;
                  error_count      <= '0;
                  first_error_addr <= '0;
                  addr             <= START_ADDR;
                  word_idx         <= '0;
                  wr_mask          <= '1;
                  tmr_clear        <= 1'b1;
                  state            <= WAIT_READY;
               end
               WAIT_READY: if (soc_side_ready_port && !soc_side_busy_port) begin
                  wr_data   <= pattern(addr, SEED);
                  wr_en     <= 1'b1;
                  tmr_clear <= 1'b1;
                  state     <= WR_REQ;
               end
               WR_REQ: if (soc_side_busy_port) begin
                  wr_en     <= 1'b0;
                  tmr_clear <= 1'b1;
                  state     <= WR_WAIT;
               end
               WR_WAIT: if (!soc_side_busy_port) begin
                  tmr_clear <= 1'b1;
                  if (word_idx == LAST_IDX) begin
                     addr     <= START_ADDR;
                     word_idx <= '0;
                     rd_en    <= 1'b1;
                     state    <= RD_REQ;
                  end else begin
                     addr     <= addr + 1'b1;
                     word_idx <= word_idx + 1'b1;
                     wr_data  <= pattern(addr + 1'b1, SEED);
                     wr_en    <= 1'b1;
                     state    <= WR_REQ;
                  end
               end
               RD_REQ: if (soc_side_busy_port) begin
                  rd_en     <= 1'b0;
                  tmr_clear <= 1'b1;
                  state     <= RD_WAIT;
               end
               RD_WAIT: if (!soc_side_busy_port) begin
                  rd_capture <= soc_side_rd_data_port;
                  state      <= CHECK;
               end
               CHECK: begin
                  if (mismatch) begin
                     if (error_count == '0) first_error_addr <= addr;
                     if (error_count != 16'hFFFF) error_count <= error_count + 1'b1;
                  end
                  if (word_idx == LAST_IDX) begin
                     done  <= 1'b1;
                     pass  <= !mismatch && (error_count == '0);
                     state <= DONE;
                  end else begin
                     addr      <= addr + 1'b1;
                     word_idx  <= word_idx + 1'b1;
                     rd_en     <= 1'b1;
                     tmr_clear <= 1'b1;
                     state     <= RD_REQ;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign soc_side_addr_port    = addr;
   assign soc_side_wr_data_port = wr_data;
   assign soc_side_wr_mask_port = wr_mask;
   assign soc_side_wr_en_port   = wr_en;
   assign soc_side_rd_en_port   = rd_en;
   assign done_port             = done;
   assign pass_port             = pass;
   assign timeout_port          = timeout;
   assign error_count_port      = error_count;
   assign first_error_addr_port = first_error_addr;

endmodule

// File: doc/sdram_test_master.md
SDRAM_TEST_MASTER -- requirements
Module: sdram_test_master

Interface
REQ-001 SHALL have parameter START_ADDR, default 23'd0, first word address tested.
REQ-002 SHALL have parameter WORD_COUNT, default 1024, number of 32-bit words tested (1..2^23).
REQ-003 SHALL have parameter SEED, default 32'hCCF0_F0F1, pattern XOR key.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, max cycles waiting on any controller handshake edge.
REQ-005 SHALL have ports, one per line:
  clk  in  1  single clock; all logic on rising edge
  reset_port  in  1  reset, synchronous, active-high
  start_port  in  1  pulse: begin test run (ignored unless idle)
  soc_side_ready_port  in  1  controller init complete
  soc_side_busy_port  in  1  controller operation in progress
  soc_side_addr_port  out  23  word address to controller
  soc_side_wr_data_port  out  32  write data
  soc_side_wr_mask_port  out  4  byte enables (always 4'b1111)
  soc_side_wr_en_port  out  1  write request
  soc_side_rd_en_port  out  1  read request
  soc_side_rd_data_port  in  32  read data from controller
  done_port  out  1  run finished (held until next start or reset)
  pass_port  out  1  valid with done: zero mismatches, no timeout
  timeout_port  out  1  a handshake exceeded TIMEOUT_CYCLES
  error_count_port  out  16  mismatch count, saturating at 16'hFFFF
  first_error_addr_port  out  23  address of first mismatch

Function
REQ-006 SHALL generate pattern data(a) = {9'b0, a} XOR SEED for word address a.
REQ-007 SHALL use states IDLE, WAIT_READY, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, DONE.
REQ-008 IDLE: on start_port=1 SHALL clear done/pass/timeout/error_count/first_error_addr, load addr=START_ADDR, go WAIT_READY.
REQ-009 WAIT_READY: SHALL go WR_REQ on the first cycle with ready=1 and busy=0.
REQ-010 WR_REQ: SHALL drive addr, wr_data=data(addr), mask 4'b1111, wr_en=1; hold all stable until busy seen 1, then deassert wr_en next cycle and go WR_WAIT.
REQ-011 WR_WAIT: on busy=0 SHALL advance addr; after WORD_COUNT writes reset addr=START_ADDR, go RD_REQ, else go WR_REQ.
REQ-012 RD_REQ: SHALL drive addr, rd_en=1, hold until busy seen 1, deassert rd_en next cycle, go RD_WAIT.
REQ-013 RD_WAIT: SHALL capture rd_data on the first cycle busy=0, go CHECK.
REQ-014 CHECK (1 cycle): mismatch SHALL increment error_count (saturating) and, if count was 0, record first_error_addr; then next address or DONE after WORD_COUNT reads.
REQ-015 wr_en and rd_en SHALL never be 1 in the same cycle; at most one request outstanding.
REQ-016 Address SHALL wrap modulo 2^23 (START_ADDR+WORD_COUNT overflow continues from 0).
REQ-017 Any wait in WAIT_READY, *_REQ or *_WAIT longer than TIMEOUT_CYCLES SHALL deassert requests, set timeout_port=1, pass_port=0, go DONE.
REQ-018 DONE: done_port=1; pass_port=1 iff error_count=0 and timeout=0; start_port SHALL restart per REQ-008.
REQ-019 start_port while not IDLE/DONE SHALL be ignored.
REQ-020 ready dropping to 0 mid-run SHALL not abort; wait states only time out.

Reset
REQ-021 reset_port=1 at a clock edge SHALL force IDLE and all outputs 0 (addr, data, mask, enables, done, pass, timeout, counts), regardless of state, including mid-request.
REQ-022 Reset SHALL take priority over start_port in the same cycle.

Structure
REQ-023 State encoding and SOC address/data widths (23, 32, 4) SHALL live in shared package sdram_pkg.
REQ-024 Timeout counter SHALL be sub-module sdram_timeout_counter (clear, enable, expired).
REQ-025 No memory arrays; pattern computed, not stored.

Verification
REQ-026 Ideal controller stub (busy 3 cycles after each en), WORD_COUNT=4, START_ADDR=8086 -> writes 8086..8089 with data(a), reads back, done=1, pass=1, error_count=0.
REQ-027 Stub corrupts read at 8087 (bit0 flipped) -> error_count=1, first_error_addr=8087, pass=0.
REQ-028 Stub never asserts busy after wr_en -> timeout=1 after TIMEOUT_CYCLES, wr_en=0, pass=0.
REQ-029 START_ADDR=23'h7FFFFE, WORD_COUNT=4 -> addresses 7FFFFE,7FFFFF,0,1 in order.
REQ-030 reset_port pulsed during RD_WAIT -> next cycle all outputs 0, state IDLE; fresh start completes with pass=1.
REQ-031 ready held 0 for 100 cycles after start (TIMEOUT 4096) -> no request issued until ready=1, then normal pass.
